// File: rtl/alu_stage_pkg.sv
// Shared ALU definitions: datapath width, NZCV bit positions and ARM data-processing opcodes.
package alu_stage_pkg;

  localparam int unsigned DataWidth = 32;

  localparam int unsigned FlagN = 4;
  localparam int unsigned FlagZ = 3;
  localparam int unsigned FlagC = 2;
  localparam int unsigned FlagV = 1;

  typedef enum logic [4:1] {
    OpAnd = 4'b0000,
    OpEor = 4'b0001,
    OpSub = 4'b0010,
    OpRsb = 4'b0011,
    OpAdd = 4'b0100,
    OpAdc = 4'b0101,
    OpSbc = 4'b0110,
    OpRsc = 4'b0111,
    OpTst = 4'b1000,
    OpTeq = 4'b1001,
    OpCmp = 4'b1010,
    OpCmn = 4'b1011,
    OpOrr = 4'b1100,
    OpMov = 4'b1101,
    OpBic = 4'b1110,
    OpMvn = 4'b1111
  } alu_op_e;

  // TST/TEQ/CMP/CMN share the 10xx encoding: flags only, no register write.
  function automatic logic is_compare(alu_op_e op);
    return op[4:3] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_stage_core.sv
// Combinational ARM data-processing ALU: result, NZCV candidates, flag-update and write-enable.
module alu_core
  import alu_stage_pkg::*;
(
  input  alu_op_e              i_op,
  input  logic                 i_s,
  input  logic [DataWidth:1]   i_a,
  input  logic [DataWidth:1]   i_b,
  input  logic                 i_shift_carry,
  input  logic                 i_carry,
  input  logic                 i_v,
  output logic [DataWidth:1]   o_result,
  output logic                 o_n,
  output logic                 o_z,
  output logic                 o_c,
  output logic                 o_v,
  output logic                 o_flag_upd,
  output logic                 o_write_en
);

  logic [DataWidth:1]   w_x;
  logic [DataWidth:1]   w_y;
  logic                 w_cin;
  logic                 w_arith;
  logic [DataWidth+1:1] w_sum;

  // Every arithmetic op reduces to x + y + cin on one 33-bit adder.
  always_comb begin
    w_x     = '0;
    w_y     = '0;
    w_cin   = 1'b0;
    w_arith = 1'b1;
    unique case (i_op)
      OpAdd, OpCmn: begin w_x = i_a; w_y = i_b;  w_cin = 1'b0;    end
      OpAdc:        begin w_x = i_a; w_y = i_b;  w_cin = i_carry; end
      OpSub, OpCmp: begin w_x = i_a; w_y = ~i_b; w_cin = 1'b1;    end
      OpSbc:        begin w_x = i_a; w_y = ~i_b; w_cin = i_carry; end
      OpRsb:        begin w_x = i_b; w_y = ~i_a; w_cin = 1'b1;    end
      OpRsc:        begin w_x = i_b; w_y = ~i_a; w_cin = i_carry; end
      default:      w_arith = 1'b0;
    endcase
  end

  assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{DataWidth{1'b0}}, w_cin};

  always_comb begin
    o_result = w_sum[DataWidth:1];
    unique case (i_op)
      OpAnd, OpTst: o_result = i_a & i_b;
      OpEor, OpTeq: o_result = i_a ^ i_b;
      OpOrr:        o_result = i_a | i_b;
      OpMov:        o_result = i_b;
      OpBic:        o_result = i_a & ~i_b;
      OpMvn:        o_result = ~i_b;
      default:      o_result = w_sum[DataWidth:1];
    endcase
  end

  assign o_n        = o_result[DataWidth];
  assign o_z        = (o_result == '0);
  assign o_c        = w_arith ? w_sum[DataWidth+1] : i_shift_carry;
  assign o_v        = w_arith ? ((w_x[DataWidth] == w_y[DataWidth]) &&
                                 (w_sum[DataWidth] != w_x[DataWidth])) : i_v;
  assign o_flag_upd = i_s | is_compare(i_op);
  assign o_write_en = ~is_compare(i_op);

endmodule

// File: rtl/alu_stage.sv
// Registered ALU stage: valid/ready handshake, result register and architectural NZCV flags.
module alu_stage
  import alu_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  input  logic [4:1]           ALU_OP,
  input  logic                 S,
  input  logic [DataWidth:1]   Operand_A,
  input  logic [DataWidth:1]   Shift_Out,
  input  logic                 Shift_Carry_Out,
  output logic                 Out_Valid,
  input  logic                 Out_Ready,
  output logic [DataWidth:1]   ALU_Out,
  output logic                 Write_En,
  output logic [4:1]           NZCV,
  output logic                 Carry_flag
);

  logic                 r_out_valid;
  logic [DataWidth:1]   r_alu_out;
  logic                 r_write_en;
  logic [4:1]           r_nzcv;

  logic                 w_accept;
  logic [DataWidth:1]   w_result;
  logic                 w_n;
  logic                 w_z;
  logic                 w_c;
  logic                 w_v;
  logic                 w_flag_upd;
  logic                 w_write_en;

  assign In_Ready = ~r_out_valid | Out_Ready;
  assign w_accept = In_Valid & In_Ready;

  alu_core u_alu_core (
    .i_op          (alu_op_e'(ALU_OP)),
    .i_s           (S),
    .i_a           (Operand_A),
    .i_b           (Shift_Out),
    .i_shift_carry (Shift_Carry_Out),
    .i_carry       (r_nzcv[FlagC]),
    .i_v           (r_nzcv[FlagV]),
    .o_result      (w_result),
    .o_n           (w_n),
    .o_z           (w_z),
    .o_c           (w_c),
    .o_v           (w_v),
    .o_flag_upd    (w_flag_upd),
    .o_write_en    (w_write_en)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_alu_out   <= '0;
      r_write_en  <= 1'b0;
      r_nzcv      <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_alu_out   <= w_result;
      r_write_en  <= w_write_en;
      if (w_flag_upd) begin
        r_nzcv[FlagN] <= w_n;
        r_nzcv[FlagZ] <= w_z;
        r_nzcv[FlagC] <= w_c;
        r_nzcv[FlagV] <= w_v;
      end
    end else if (Out_Ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign Out_Valid  = r_out_valid;
  assign ALU_Out    = r_alu_out;
  assign Write_En   = r_write_en;
  assign NZCV       = r_nzcv;
  assign Carry_flag = r_nzcv[FlagC];

endmodule

// File: tb/tb_alu_stage.sv
// Self-checking bench for alu_stage: directed scenarios plus randomized traffic against an arithmetic model.
module tb_alu_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic        s_bit;
  logic [31:0] op_a;
  logic [31:0] shift_out;
  logic        shift_carry;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_out;
  logic        write_en;
  logic [3:0]  nzcv;
  logic        carry_flag;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: what the stage should be presenting now.
  logic        m_valid;
  logic [31:0] m_out;
  logic        m_we;
  logic [3:0]  m_nzcv;

  alu_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .In_Valid        (in_valid),
    .In_Ready        (in_ready),
    .ALU_OP          (alu_op),
    .S               (s_bit),
    .Operand_A       (op_a),
    .Shift_Out       (shift_out),
    .Shift_Carry_Out (shift_carry),
    .Out_Valid       (out_valid),
    .Out_Ready       (out_ready),
    .ALU_Out         (alu_out),
    .Write_En        (write_en),
    .NZCV            (nzcv),
    .Carry_flag      (carry_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ARM semantics via signed/unsigned integer arithmetic; nzcv bit 3=N, 2=Z, 1=C, 0=V.
  function automatic void ref_op(input logic [3:0] op, input logic s, input logic [31:0] a,
                                 input logic [31:0] b, input logic sc, input logic [3:0] f_in,
                                 output logic [31:0] res, output logic [3:0] f_out,
                                 output logic we);
    longint la, lb, sa, sb, sr, c, br;
    logic   carry, v;
    bit     arith, cmp;
    la = a; lb = b; sa = $signed(a); sb = $signed(b);
    c  = f_in[1]; br = 1 - c;
    arith = 1'b1; carry = sc; v = f_in[0]; sr = 0;
    case (op)
      4'h4, 4'hB: begin sr = sa + sb;      carry = (la + lb > 64'd4294967295);     end
      4'h5:       begin sr = sa + sb + c;  carry = (la + lb + c > 64'd4294967295); end
      4'h2, 4'hA: begin sr = sa - sb;      carry = (la >= lb);                     end
      4'h6:       begin sr = sa - sb - br; carry = (la >= lb + br);                end
      4'h3:       begin sr = sb - sa;      carry = (lb >= la);                     end
      4'h7:       begin sr = sb - sa - br; carry = (lb >= la + br);                end
      default:    arith = 1'b0;
    endcase
    if (arith) begin
      res = sr[31:0];
      v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    end else begin
      case (op)
        4'h0, 4'h8: res = a & b;
        4'h1, 4'h9: res = a ^ b;
        4'hC:       res = a | b;
        4'hD:       res = b;
        4'hE:       res = a & ~b;
        default:    res = ~b;
      endcase
    end
    cmp = (op >= 4'h8) && (op <= 4'hB);
    we  = !cmp;
    f_out = (s || cmp) ? {res[31], res == 32'd0, carry, v} : f_in;
  endfunction

  task automatic drive(input logic v, input logic [3:0] op, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic sc);
    in_valid = v; alu_op = op; s_bit = s; op_a = a; shift_out = b; shift_carry = sc;
  endtask

  // Advance one clock, stepping the reference state with the inputs currently driven.
  task automatic tick();
    logic acc;
    logic [31:0] r;
    logic [3:0]  f;
    logic        w;
    acc = in_valid && (!m_valid || out_ready);
    if (acc) begin
      ref_op(alu_op, s_bit, op_a, shift_out, shift_carry, m_nzcv, r, f, w);
      m_valid = 1'b1; m_out = r; m_we = w; m_nzcv = f;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'(1);
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    drive(1'b0, 4'h0, 1'b0, 32'd0, 32'd0, 1'b0);
    out_ready = 1'b1;
    rst_n = 1'b0;
    #3;
    n_checks++;
    if ({out_valid, alu_out, write_en, nzcv, carry_flag} !== 39'd0) begin
      n_errors++;
      $display("FAIL reset_initial: got valid=%b out=%h we=%b nzcv=%b cf=%b, want all zero",
               out_valid, alu_out, write_en, nzcv, carry_flag);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    // Get a result with flags held, then reset mid-stream.
    out_ready = 1'b0;
    drive(1'b1, 4'h2, 1'b1, 32'd0, 32'd1, 1'b0);
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || nzcv !== 4'b1000) begin
      n_errors++;
      $display("FAIL reset_prefill: got valid=%b nzcv=%b, want 1 1000", out_valid, nzcv);
    end
    drive(1'b0, 4'h0, 1'b0, 32'd0, 32'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    m_valid = 1'b0; m_out = '0; m_we = 1'b0; m_nzcv = '0;
    n_checks++;
    if ({out_valid, alu_out, write_en, nzcv, carry_flag} !== 39'd0) begin
      n_errors++;
      $display("FAIL reset_async: got valid=%b out=%h we=%b nzcv=%b cf=%b, want all zero",
               out_valid, alu_out, write_en, nzcv, carry_flag);
    end
    @(negedge clk); rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_in_ready: got %b, want 1", in_ready);
    end
    tick();
  endtask

  task automatic test_add_overflow();
    drive(1'b1, 4'h4, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || alu_out !== 32'h8000_0000 || nzcv !== 4'b1001 ||
        write_en !== 1'b1) begin
      n_errors++;
      $display("FAIL add_overflow: got v=%b out=%h nzcv=%b we=%b, want 1 80000000 1001 1",
               out_valid, alu_out, nzcv, write_en);
    end
  endtask

  task automatic test_cmp();
    drive(1'b1, 4'hA, 1'b0, 32'd5, 32'd5, 1'b0);
    tick();
    n_checks++;
    if (write_en !== 1'b0 || nzcv !== 4'b0110) begin
      n_errors++;
      $display("FAIL cmp_equal: got we=%b nzcv=%b, want 0 0110", write_en, nzcv);
    end
    drive(1'b1, 4'h2, 1'b1, 32'd0, 32'd1, 1'b0);
    tick();
    n_checks++;
    if (alu_out !== 32'hFFFF_FFFF || nzcv !== 4'b1000 || write_en !== 1'b1) begin
      n_errors++;
      $display("FAIL subs_borrow: got out=%h nzcv=%b we=%b, want ffffffff 1000 1",
               alu_out, nzcv, write_en);
    end
  endtask

  task automatic test_logical_carry();
    drive(1'b1, 4'h4, 1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0);
    tick();
    drive(1'b1, 4'hD, 1'b1, 32'd0, 32'd1, 1'b0);
    tick();
    n_checks++;
    if (nzcv !== 4'b0001) begin
      n_errors++;
      $display("FAIL logical_prior: got nzcv=%b, want 0001", nzcv);
    end
    drive(1'b1, 4'hD, 1'b1, 32'h1234_5678, 32'hAAAA_FF00, 1'b1);
    tick();
    n_checks++;
    if (alu_out !== 32'hAAAA_FF00 || nzcv !== 4'b1011) begin
      n_errors++;
      $display("FAIL movs_shift_carry: got out=%h nzcv=%b, want aaaaff00 1011", alu_out, nzcv);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 4'h4, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0);
    tick();
    n_checks++;
    if (alu_out !== 32'd0 || nzcv !== 4'b0110 || carry_flag !== 1'b1) begin
      n_errors++;
      $display("FAIL adds_carry: got out=%h nzcv=%b cf=%b, want 00000000 0110 1",
               alu_out, nzcv, carry_flag);
    end
    drive(1'b1, 4'h5, 1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    n_checks++;
    if (alu_out !== 32'd1 || nzcv !== 4'b0110 || out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL adc_chain: got out=%h nzcv=%b v=%b, want 00000001 0110 1",
               alu_out, nzcv, out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held_out;
    logic [3:0]  held_nzcv;
    drive(1'b1, 4'h4, 1'b1, 32'd3, 32'd4, 1'b0);
    tick();
    held_out = 32'd7; held_nzcv = 4'b0000;
    out_ready = 1'b0;
    drive(1'b1, 4'h2, 1'b1, 32'd0, 32'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL stall_in_ready[%0d]: got %b, want 0", i, in_ready);
      end
      tick();
      n_checks++;
      if (alu_out !== held_out || nzcv !== held_nzcv || out_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL stall_hold[%0d]: got out=%h nzcv=%b v=%b, want %h %b 1",
                 i, alu_out, nzcv, out_valid, held_out, held_nzcv);
      end
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL release_in_ready: got %b, want 1", in_ready);
    end
    tick();
    n_checks++;
    if (alu_out !== 32'hFFFF_FFFF || nzcv !== 4'b1000 || out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL release_result: got out=%h nzcv=%b v=%b, want ffffffff 1000 1",
               alu_out, nzcv, out_valid);
    end
    drive(1'b0, 4'h0, 1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL drain: got valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            rand_word(), rand_word(), 1'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      n_checks++;
      if (in_ready !== (!m_valid || out_ready)) begin
        n_errors++;
        $display("FAIL rand_in_ready[%0d]: got %b, want %b", i, in_ready, !m_valid || out_ready);
      end
      tick();
      n_checks++;
      if (out_valid !== m_valid || nzcv !== m_nzcv || carry_flag !== m_nzcv[1]) begin
        n_errors++;
        $display("FAIL rand_state[%0d]: got v=%b nzcv=%b cf=%b, want %b %b %b",
                 i, out_valid, nzcv, carry_flag, m_valid, m_nzcv, m_nzcv[1]);
      end
      if (m_valid) begin
        n_checks++;
        if (alu_out !== m_out || write_en !== m_we) begin
          n_errors++;
          $display("FAIL rand_result[%0d]: op=%h got out=%h we=%b, want %h %b",
                   i, alu_op, alu_out, write_en, m_out, m_we);
        end
      end
    end
    drive(1'b0, 4'h0, 1'b0, 32'd0, 32'd0, 1'b0);
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    m_valid = 1'b0; m_out = '0; m_we = 1'b0; m_nzcv = '0;
    test_reset();
    test_add_overflow();
    test_cmp();
    test_logical_carry();
    test_back_to_back();
    test_backpressure();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_stage.md
# alu_stage

Single-stage, registered ARM data-processing ALU that directly consumes the barrel shifter's outputs (`Shift_Out` as operand 2, `Shift_Carry_Out` as shifter carry) together with operand 1 (Rn). It executes the 16 ARM data-processing opcodes and holds the architectural NZCV flags. It returns the current C flag to the shifter as `Carry_flag` for RRX and ADC/SBC/RSC. Input and output use valid/ready handshakes, so the stage can stall behind writeback.

## Interface
Parameters: none (fixed 32-bit datapath, 1-based bit numbering).

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `In_Valid` in 1: an operation is presented.
- `In_Ready` out 1: the stage accepts an operation this cycle.
- `ALU_OP` in [4:1]: ARM opcode.
- `S` in 1: set-flags bit.
- `Operand_A` in [32:1]: Rn.
- `Shift_Out` in [32:1]: operand 2, taken from the shifter.
- `Shift_Carry_Out` in 1: shifter carry.
- `Out_Valid` out 1: a result is held.
- `Out_Ready` in 1: downstream takes the result.
- `ALU_Out` out [32:1]: registered result.
- `Write_En` out 1: result is to be written to Rd.
- `NZCV` out [4:1]: flag register; N=[4], Z=[3], C=[2], V=[1].
- `Carry_flag` out 1: equals `NZCV[2]`; drives the shifter.

## Operation
- **Opcodes:**
  - 0000 AND, 0001 EOR, 0010 SUB, 0011 RSB
  - 0100 ADD, 0101 ADC, 0110 SBC, 0111 RSC
  - 1000 TST, 1001 TEQ, 1010 CMP, 1011 CMN
  - 1100 ORR, 1101 MOV, 1110 BIC, 1111 MVN
- **Arithmetic:** A=`Operand_A`, B=`Shift_Out`, using a 33-bit sum.
  - ADD: A+B. ADC: A+B+C.
  - SUB: A+~B+1. SBC: A+~B+C.
  - RSB: B+~A+1. RSC: B+~A+C.
  - CMP is computed as SUB; CMN is computed as ADD.
  - C = bit 33 of the sum (for subtraction this means C=1 when there is no borrow).
  - V = signed overflow: the two adder inputs have the same sign and the result sign differs.
- **Logical ops** (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN):
  - C = `Shift_Carry_Out`.
  - V is unchanged.
  - MOV = B, MVN = ~B, BIC = A & ~B.
- **N and Z:** N = result[32]; Z = (result == 0).
- **Flag update:**
  - TST, TEQ, CMP and CMN always update flags, regardless of `S`.
  - All other opcodes update flags only when `S`=1.
  - When no update occurs, NZCV holds its value.
- **Write_En:** 0 for TST, TEQ, CMP and CMN; 1 for all other opcodes. `ALU_Out` is loaded with the computed value in every case.
- **Handshake:**
  - Accept = `In_Valid` & `In_Ready`.
  - `In_Ready` = !`Out_Valid` | `Out_Ready`.
  - On accept: the output register, `Write_En` and (conditionally) NZCV load, and `Out_Valid` is set.
  - If `Out_Valid` & `Out_Ready` with no accept, `Out_Valid` clears.
  - While `Out_Valid`=1 and `Out_Ready`=0, all outputs hold.
- **Carry input:** the C flag used by ADC, SBC and RSC is the current `NZCV[2]`, sampled in the same cycle as the accept.

## Timing
- **Reset (async, any time):** `Out_Valid`=0, `ALU_Out`=0, `Write_En`=0, `NZCV`=4'b0000, `Carry_flag`=0.
  - An operation in flight is discarded.
  - `In_Ready`=1 in the first cycle after reset release.
- **Latency:** 1 cycle from accept to `Out_Valid`.
- **Throughput:** 1 operation per cycle while `Out_Ready`=1.
- **Flag visibility:** NZCV updates on the accepting edge, so a dependent ADC accepted on the very next cycle sees the new C. `Carry_flag` to the shifter also reflects it from that edge onward.
- **Simultaneous events:** an accept in the same cycle as an output drain replaces the output register with the new operation; there is no bubble.
- **Not accepted:** with `In_Valid`=1 and `In_Ready`=0 the operation is not consumed, and NZCV does not change.

## Structure
- **Shared package** (shared with shifter/decoder):
  - `ALU_OP` encodings as named constants.
  - NZCV bit-position constants.
  - Data width constant (32).
- **One sub-module `alu_core`:**
  - Purely combinational: opcode → result[32:1], n, z, c, v, flag-update, write-enable.
  - The top level holds only the handshake, the output register and the NZCV register.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream with `Out_Valid`=1 → `Out_Valid`=0, `ALU_Out`=0, `NZCV`=0000, `Carry_flag`=0 immediately; `In_Ready`=1 after release.
- **ADD overflow:** ADD S=1, A=0x7FFFFFFF, B=0x00000001 → one cycle later `ALU_Out`=0x80000000, `NZCV`=1001, `Write_En`=1.
- **CMP:** CMP, A=5, B=5, S=0 → `Write_En`=0, `NZCV`=0110; then SUBS A=0, B=1 → `ALU_Out`=0xFFFFFFFF, `NZCV`=1000.
- **Logical carry from shifter:** prior NZCV=0001; MOVS, B=0xAAAAFF00, `Shift_Carry_Out`=1 → `ALU_Out`=0xAAAAFF00, `NZCV`=1011 (V held).
- **Back-to-back carry chain:** ADDS A=0xFFFFFFFF, B=1 → 0x00000000, `NZCV`=0110, `Carry_flag`=1. ADC A=0, B=0 accepted next cycle → `ALU_Out`=0x00000001, NZCV unchanged.
- **Backpressure:** `Out_Ready`=0 for 3 cycles with `In_Valid`=1 → `In_Ready`=0 and `ALU_Out`/NZCV stable. On `Out_Ready`=1 the pending operation is accepted in that same cycle, and its result appears on the next cycle.
